// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the LED pattern engine.
//   mode_e  : 2-bit pattern request encoding (off / solid / blink / breathe)
//   state_e : pattern FSM states
//   LED_ON / LED_OFF : pin levels for active-low LEDs
//   entry_state() : FSM state loaded when a new mode is applied
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_SOLID   = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        OFF          = 3'd0,
        SOLID        = 3'd1,
        BLINK_ON     = 3'd2,
        BLINK_OFF    = 3'd3,
        BREATHE_UP   = 3'd4,
        BREATHE_DOWN = 3'd5
    } state_e;

    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    // Each mode starts its pattern from a fixed state.
    function automatic state_e entry_state(input mode_e m);
        state_e st;
        case (m)
            MODE_OFF:     st = OFF;
            MODE_SOLID:   st = SOLID;
            MODE_BLINK:   st = BLINK_ON;
            MODE_BREATHE: st = BREATHE_UP;
            default:      st = OFF;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/led_pattern_driver_prescaler.sv
// -----------------------------------------------------------------------------
// led_prescaler
// Free-running PRESCALE_W-bit counter producing a one-cycle slow enable.
// tick is registered and is high exactly while the count is all-ones, so a
// tick occurs once every 2^PRESCALE_W clocks.
// Ports:
//   clk_osc : clock
//   reset   : asynchronous active-low reset (count = 0, tick = 0)
//   tick    : one-cycle strobe
// -----------------------------------------------------------------------------
module led_prescaler
    import led_pkg::*;
#(
    parameter int PRESCALE_W = 20
) (
    input  logic clk_osc,
    input  logic reset,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] CNT_ONE  = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] CNT_LAST = {PRESCALE_W{1'b1}};
    // Registering the compare one count early aligns tick with the all-ones count.
    localparam logic [PRESCALE_W-1:0] CNT_PRE  = CNT_LAST - CNT_ONE;

    logic [PRESCALE_W-1:0] cnt_r;
    logic                  tick_r;

    // Prescale counter and registered tick strobe.
    always_ff @(posedge clk_osc or negedge reset) begin
        if (!reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_r + CNT_ONE;
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/led_pattern_driver.sv
// -----------------------------------------------------------------------------
// led_pattern_driver
// Single-clock LED pattern engine: off, solid, blink and PWM breathe patterns
// on NUM_LEDS active-low pins, advanced by a prescaler tick enable.
// Ports:
//   clk_osc : oscillator clock, sole clock
//   reset   : asynchronous active-low reset
//   mode    : requested pattern (asynchronous pins), 00 off / 01 solid /
//             10 blink / 11 breathe
//   led     : active-low LED drive (registered)
//   tick    : one-cycle prescaler strobe (registered)
// Build option:
//   LED_ALT_PHASE_EN : when defined, odd-indexed LEDs blink in antiphase and
//                      breathe against the inverted duty.
// -----------------------------------------------------------------------------
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int PRESCALE_W  = 20,
    parameter int BLINK_TICKS = 32,
    parameter int PWM_W       = 8,
    parameter int NUM_LEDS    = 2
) (
    input  logic                clk_osc,
    input  logic                reset,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

`ifdef LED_ALT_PHASE_EN
    localparam logic ALT_EN = 1'b1;
`else
    localparam logic ALT_EN = 1'b0;
`endif

    localparam logic [7:0]       BLINK_LAST = 8'(BLINK_TICKS - 1);
    localparam logic [7:0]       BLINK_ONE  = 8'd1;
    localparam logic [PWM_W-1:0] DUTY_MAX   = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] PWM_ONE    = PWM_W'(1);

    logic [1:0]          mode_meta_r;
    logic [1:0]          mode_sync_r;   // mode_s: synchronised request
    logic                tick_s;
    state_e              state_r, state_n;
    mode_e               applied_r, applied_n;
    logic [7:0]          blink_cnt_r, blink_cnt_n;
    logic [PWM_W-1:0]    duty_r, duty_n;
    logic [PWM_W-1:0]    pwm_cnt_r;
    logic [NUM_LEDS-1:0] led_r, led_n;

    led_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_osc (clk_osc),
        .reset   (reset),
        .tick    (tick_s)
    );

    // Drive level of one LED; odd selects the antiphase variant.
    function automatic logic led_bit(input state_e st, input logic [PWM_W-1:0] duty,
                                     input logic [PWM_W-1:0] pwm, input logic odd);
        logic [PWM_W-1:0] level;
        logic             lit;
        level = odd ? (DUTY_MAX - duty) : duty;
        case (st)
            OFF:          lit = 1'b0;
            SOLID:        lit = 1'b1;
            BLINK_ON:     lit = ~odd;
            BLINK_OFF:    lit = odd;
            BREATHE_UP,
            BREATHE_DOWN: lit = (pwm < level);
            default:      lit = 1'b0;
        endcase
        return lit ? LED_ON : LED_OFF;
    endfunction

    // Two-flop synchroniser for the asynchronous mode pins.
    always_ff @(posedge clk_osc or negedge reset) begin
        if (!reset) begin
            mode_meta_r <= 2'b00;
            mode_sync_r <= 2'b00;
        end else begin
            mode_meta_r <= mode;
            mode_sync_r <= mode_meta_r;
        end
    end

    // Pattern FSM state and its counters.
    always_ff @(posedge clk_osc or negedge reset) begin
        if (!reset) begin
            state_r     <= OFF;
            applied_r   <= MODE_OFF;
            blink_cnt_r <= 8'd0;
            duty_r      <= '0;
        end else begin
            state_r     <= state_n;
            applied_r   <= applied_n;
            blink_cnt_r <= blink_cnt_n;
            duty_r      <= duty_n;
        end
    end

    // Next-state logic: everything advances only on a tick; a changed mode
    // restarts its pattern and pre-empts the normal step on that tick.
    always_comb begin
        state_n     = state_r;
        applied_n   = applied_r;
        blink_cnt_n = blink_cnt_r;
        duty_n      = duty_r;
        if (tick_s) begin
            if (mode_sync_r != applied_r) begin
                applied_n   = mode_e'(mode_sync_r);
                state_n     = entry_state(mode_e'(mode_sync_r));
                blink_cnt_n = 8'd0;
                duty_n      = '0;
            end else begin
                case (state_r)
                    BLINK_ON: begin
                        if (blink_cnt_r == BLINK_LAST) begin
                            state_n     = BLINK_OFF;
                            blink_cnt_n = 8'd0;
                        end else begin
                            blink_cnt_n = blink_cnt_r + BLINK_ONE;
                        end
                    end
                    BLINK_OFF: begin
                        if (blink_cnt_r == BLINK_LAST) begin
                            state_n     = BLINK_ON;
                            blink_cnt_n = 8'd0;
                        end else begin
                            blink_cnt_n = blink_cnt_r + BLINK_ONE;
                        end
                    end
                    // The turn-around tick only changes direction, so the
                    // peak and trough duty each last two ticks.
                    BREATHE_UP: begin
                        if (duty_r == DUTY_MAX) begin
                            state_n = BREATHE_DOWN;
                        end else begin
                            duty_n = duty_r + PWM_ONE;
                        end
                    end
                    BREATHE_DOWN: begin
                        if (duty_r == '0) begin
                            state_n = BREATHE_UP;
                        end else begin
                            duty_n = duty_r - PWM_ONE;
                        end
                    end
                    OFF, SOLID: begin
                        state_n = state_r;
                    end
                    default: begin
                        state_n   = OFF;
                        applied_n = MODE_OFF;
                    end
                endcase
            end
        end else begin
            state_n = state_r;
        end
    end

    // Free-running PWM counter.
    always_ff @(posedge clk_osc or negedge reset) begin
        if (!reset) begin
            pwm_cnt_r <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
        end
    end

    // Combinational LED levels from the current state, duty and PWM count.
    always_comb begin
        led_n = {NUM_LEDS{LED_OFF}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_n[i] = led_bit(state_r, duty_r, pwm_cnt_r, ALT_EN & ((i % 2) == 1));
        end
    end

    // Registered LED outputs.
    always_ff @(posedge clk_osc or negedge reset) begin
        if (!reset) begin
            led_r <= {NUM_LEDS{LED_OFF}};
        end else begin
            led_r <= led_n;
        end
    end

    assign led  = led_r;
    assign tick = tick_s;

endmodule

// File: tb/tb_led_pattern_driver.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_driver
// Directed bench for led_pattern_driver with PRESCALE_W=4, BLINK_TICKS=3,
// PWM_W=3, NUM_LEDS=2. Expected values are hand-derived; build with
// LED_ALT_PHASE_EN defined to check the antiphase variant.
// -----------------------------------------------------------------------------
module tb_led_pattern_driver;

`ifdef LED_ALT_PHASE_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif
    localparam logic [1:0] ON_PAT  = ALT ? 2'b10 : 2'b00;
    localparam logic [1:0] OFF_PAT = ALT ? 2'b01 : 2'b11;

    logic       clk_osc;
    logic       reset;
    logic [1:0] mode;
    logic [1:0] led;
    logic       tick;

    int n_total;
    int n_bad;

    led_pattern_driver #(
        .PRESCALE_W  (4),
        .BLINK_TICKS (3),
        .PWM_W       (3),
        .NUM_LEDS    (2)
    ) dut (
        .clk_osc (clk_osc),
        .reset   (reset),
        .mode    (mode),
        .led     (led),
        .tick    (tick)
    );

    initial clk_osc = 1'b0;
    always #5 clk_osc = ~clk_osc;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to the next negedge at which tick is high (bounded).
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk_osc);
            n++;
        end while (tick !== 1'b1 && n < 40);
        if (tick !== 1'b1) check_eq("tick_timeout", 0, 1);
    endtask

    // Called at the negedge where reset was released: no tick and dark LEDs
    // for 14 clocks, tick on the 15th edge.
    task automatic first_tick_after_release(input string tag);
        int early;
        early = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk_osc);
            if (i < 15) begin
                if (tick !== 1'b0 || led !== 2'b11) early++;
            end else begin
                check_eq({tag, "_tick"}, int'(tick), 1);
            end
        end
        check_eq({tag, "_pre_tick"}, early, 0);
    endtask

    // Called at the negedge of a tick cycle: count lit clocks over 8 cycles
    // of the duty that tick establishes.
    task automatic measure(input int d, input string tag);
        int c0, c1;
        c0 = 0;
        c1 = 0;
        @(negedge clk_osc);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_osc);
            if (led[0] === 1'b0) c0++;
            if (led[1] === 1'b0) c1++;
        end
        check_eq({tag, "_led0"}, c0, d);
        check_eq({tag, "_led1"}, c1, ALT ? 7 - d : d);
    endtask

    // Count samples over n clocks that differ from an expected pattern.
    task automatic hold_check(input string tag, input int n, input logic [1:0] exp);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_osc);
            if (led !== exp) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    initial begin
        int seq [22] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0, 1, 2, 3, 4, 5};
        int n;
        int bad;
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        mode    = 2'b01;
        #1 reset = 1'b0;

        // 1. reset with solid requested
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_osc);
            if (led !== 2'b11 || tick !== 1'b0) bad++;
        end
        check_eq("rst_hold", bad, 0);
        reset = 1'b1;
        first_tick_after_release("rst1");
        @(negedge clk_osc);
        check_eq("solid_lag_led", int'(led), 3);
        check_eq("solid_lag_tick", int'(tick), 0);
        @(negedge clk_osc);
        check_eq("solid_on", int'(led), 0);

        // 2. blink: 48 on, 48 off, 48 on
        mode = 2'b10;
        wait_tick();
        @(negedge clk_osc);
        hold_check("blink_on1", 48, ON_PAT);
        hold_check("blink_off1", 48, OFF_PAT);
        hold_check("blink_on2", 48, ON_PAT);
        wait_tick();
        n = 0;
        do begin
            @(negedge clk_osc);
            n++;
        end while (tick !== 1'b1 && n < 40);
        check_eq("tick_period", n, 16);

        // 4a. mode held at 00 across a tick, then back to 10: restart
        wait_tick();
        mode = 2'b00;
        wait_tick();
        @(negedge clk_osc);
        @(negedge clk_osc);
        check_eq("mc_off", int'(led), 3);
        mode = 2'b10;
        wait_tick();
        @(negedge clk_osc);
        @(negedge clk_osc);
        check_eq("mc_restart", int'(led), int'(ON_PAT));

        // 4b. 5-clock glitch to 00 between ticks: ignored, no restart
        mode = 2'b00;
        hold_check("mc_glitch_hold", 5, ON_PAT);
        mode = 2'b10;
        wait_tick();
        @(negedge clk_osc);
        @(negedge clk_osc);
        check_eq("mc_glitch_ign", int'(led), int'(ON_PAT));
        wait_tick();
        @(negedge clk_osc);
        @(negedge clk_osc);
        check_eq("mc_cnt2", int'(led), int'(ON_PAT));
        wait_tick();
        @(negedge clk_osc);
        @(negedge clk_osc);
        check_eq("mc_no_restart", int'(led), int'(OFF_PAT));

        // 3. breathe ramp, including the two-tick turn-arounds
        mode = 2'b11;
        for (int k = 0; k < 22; k++) begin
            wait_tick();
            measure(seq[k], $sformatf("breathe%0d", k));
        end

        // 5. async reset at duty 5 while led[0] is lit
        n = 0;
        while (led[0] !== 1'b0 && n < 6) begin
            @(negedge clk_osc);
            n++;
        end
        check_eq("rst5_lit_before", int'(led[0]), 0);
        #2 reset = 1'b0;
        #1;
        check_eq("rst5_async_led", int'(led), 3);
        check_eq("rst5_async_tick", int'(tick), 0);
        @(negedge clk_osc);
        @(negedge clk_osc);
        reset = 1'b1;
        first_tick_after_release("rst5");
        measure(0, "rst5_d0");
        wait_tick();
        measure(1, "rst5_d1");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
